mux_arbiter_rr: RTL

- Round-robin scheduler that shares one DATA_WIDTH output lane between four requesting input lanes (Entrada0..3).
- Each lane has a one-entry holding buffer with a valid/ready handshake.
- A registered output stage presents the granted word plus its source lane id and supports downstream back-pressure (pause).
- Sits in front of the lane-combining mux stage and replaces fixed-phase selection with fair, gap-tolerant arbitration.

---
 rtl/mux_arbiter_rr.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mux_arbiter_rr.sv
// mux_arbiter_rr
// Shares one DATA_WIDTH output lane among four input lanes using round-robin
// arbitration. Each input lane has a one-entry holding buffer with a
// valid/ready handshake. A registered output stage carries the granted word
// and its source lane id, and it holds its contents while pause is high.
//
// Ports
//   clk_4f              : clock; all state changes on its rising edge
//   reset               : asynchronous, active-high reset
//   Entrada0..3         : lane data words
//   validEntrada0..3    : lane data valid
//   readyEntrada0..3    : lane buffer empty (it can take a word this cycle)
//   pause               : downstream stall; freezes the output stage
//   Salida              : granted word
//   validSalida         : Salida holds a valid word
//   lane_id             : source lane of Salida
//   grant_count         : number of words loaded into the output stage (wraps)
module mux_arbiter_rr #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_4f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Entrada0,
  input  logic [DATA_WIDTH-1:0] Entrada1,
  input  logic [DATA_WIDTH-1:0] Entrada2,
  input  logic [DATA_WIDTH-1:0] Entrada3,
  input  logic                  validEntrada0,
  input  logic                  validEntrada1,
  input  logic                  validEntrada2,
  input  logic                  validEntrada3,
  output logic                  readyEntrada0,
  output logic                  readyEntrada1,
  output logic                  readyEntrada2,
  output logic                  readyEntrada3,
  input  logic                  pause,
  output logic [DATA_WIDTH-1:0] Salida,
  output logic                  validSalida,
  output logic [1:0]            lane_id,
  output logic [CNT_WIDTH-1:0]  grant_count
);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t                state, state_nxt;
  logic [3:0]            full;
  logic [DATA_WIDTH-1:0] lane_buf [4];
  logic [DATA_WIDTH-1:0] din [4];
  logic [3:0]            vin, rdy, acc;
  logic [1:0]            ptr, gnt_idx, cand;
  logic                  gnt_any, load_ok, do_grant;
  logic [3:0]            gnt_mask;

  assign din[0] = Entrada0;
  assign din[1] = Entrada1;
  assign din[2] = Entrada2;
  assign din[3] = Entrada3;
  assign vin    = {validEntrada3, validEntrada2, validEntrada1, validEntrada0};

  assign rdy = ~full & {4{~reset}};
  assign acc = vin & rdy;

  assign readyEntrada0 = rdy[0];
  assign readyEntrada1 = rdy[1];
  assign readyEntrada2 = rdy[2];
  assign readyEntrada3 = rdy[3];

  // HOLD behaves like SEND once pause drops, so any state loads when unpaused.
  assign load_ok = !pause;

  // First full lane at or after the pointer, in rotating order.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    cand    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!gnt_any && full[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign do_grant = load_ok && gnt_any;
  assign gnt_mask = do_grant ? (4'b0001 << gnt_idx) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (do_grant) state_nxt = SEND;
      SEND, HOLD: begin
        if (pause)        state_nxt = HOLD;
        else if (gnt_any) state_nxt = SEND;
        else              state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign validSalida = (state != IDLE);

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      full        <= '0;
      ptr         <= '0;
      Salida      <= '0;
      lane_id     <= '0;
      grant_count <= '0;
      for (int unsigned i = 0; i < 4; i++) lane_buf[i] <= '0;
    end else begin
      state <= state_nxt;
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc[i]) lane_buf[i] <= din[i];
      end
      if (do_grant) begin
        Salida      <= lane_buf[gnt_idx];
        lane_id     <= gnt_idx;
        ptr         <= gnt_idx + 2'd1;
        grant_count <= grant_count + CNT_WIDTH'(1);
      end
      // A granted lane was full, so it cannot also accept on this edge.
      full <= (full & ~gnt_mask) | acc;
    end
  end

endmodule
